// File: rtl/bp_sacc_crc32.sv
// bp_sacc_crc32: sacc-tile compute core with a CRC-32 engine behind a small CSR window.
// Accepts one uncached I/O command at a time and returns exactly one response per command.
// DATA writes are folded into the CRC one byte per cycle, least-significant byte first.
// Optional build macro: BP_SACC_CRC32_CYCLE_CNT_EN adds a 64-bit busy-cycle counter at 0x20.
module bp_sacc_crc32 #(
  // Processor config selector; 0 is the default config (40-bit physical address).
  parameter int          bp_params_p  = 0,
  parameter int          data_width_p = 64,
  parameter logic [31:0] poly_p       = 32'hEDB88320,
  localparam int         paddr_width_p = (bp_params_p == 0) ? 40 : 56
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     io_cmd_v_i,
  output logic                     io_cmd_ready_o,
  input  logic                     io_cmd_wr_i,
  input  logic [paddr_width_p-1:0] io_cmd_addr_i,
  input  logic [1:0]               io_cmd_size_i,
  input  logic [data_width_p-1:0]  io_cmd_data_i,
  output logic                     io_resp_v_o,
  input  logic                     io_resp_yumi_i,
  output logic                     io_resp_wr_o,
  output logic [paddr_width_p-1:0] io_resp_addr_o,
  output logic [data_width_p-1:0]  io_resp_data_o,
  output logic                     busy_o
);

  localparam logic [5:0] CSR_CTRL   = 6'h00;
  localparam logic [5:0] CSR_DATA   = 6'h08;
  localparam logic [5:0] CSR_RESULT = 6'h10;
  localparam logic [5:0] CSR_COUNT  = 6'h18;
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
  localparam logic [5:0] CSR_CYCLE  = 6'h20;
`endif

  typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_e;

  state_e                    state_q, state_d;
  logic                      rdy_q, rdy_d;
  logic                      wr_q, wr_d;
  logic [paddr_width_p-1:0]  addr_q, addr_d;
  logic [data_width_p-1:0]   data_q, data_d;
  logic [data_width_p-1:0]   rdata_q, rdata_d;
  logic [2:0]                bcnt_q, bcnt_d;
  logic [31:0]               crc_q, crc_d;
  logic [31:0]               count_q, count_d;
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
  logic [63:0]               cycle_q, cycle_d;
`endif

  logic [5:0] cmd_off;
  assign cmd_off = io_cmd_addr_i[5:0];

  // One reflected CRC-32 byte step: xor the byte in, then eight shift/conditional-xor rounds.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'b0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ poly_p) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state and datapath: accept/decode in IDLE, byte-serial CRC in COMPUTE, hold in RESP.
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    bcnt_d  = bcnt_q;
    crc_d   = crc_q;
    count_d = count_q;
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
    cycle_d = (state_q == COMPUTE) ? cycle_q + 64'd1 : cycle_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io_cmd_v_i && rdy_q) begin
          wr_d    = io_cmd_wr_i;
          addr_d  = io_cmd_addr_i;
          data_d  = io_cmd_data_i;
          rdata_d = '0;
          state_d = RESP;
          if (io_cmd_wr_i) begin
            case (cmd_off)
              CSR_CTRL: begin
                if (io_cmd_data_i[0]) begin
                  crc_d   = 32'hFFFF_FFFF;
                  count_d = '0;
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
                  cycle_d = '0;
`endif
                end
              end
              CSR_DATA: begin
                state_d = COMPUTE;
                case (io_cmd_size_i)
                  2'd0:    bcnt_d = 3'd0;
                  2'd1:    bcnt_d = 3'd1;
                  2'd2:    bcnt_d = 3'd3;
                  default: bcnt_d = 3'd7;
                endcase
              end
              default: ;
            endcase
          end else begin
            // Reads sample CSR state at the accept cycle.
            case (cmd_off)
              CSR_RESULT: rdata_d = data_width_p'({32'b0, ~crc_q});
              CSR_COUNT:  rdata_d = data_width_p'({32'b0, count_q});
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
              CSR_CYCLE:  rdata_d = data_width_p'(cycle_q);
`endif
              default:    rdata_d = '0;
            endcase
          end
        end
      end
      COMPUTE: begin
        crc_d   = crc_step(crc_q, data_q[7:0]);
        data_d  = data_q >> 8;
        count_d = count_q + 32'd1;
        if (bcnt_q == 3'd0) state_d = RESP;
        else                bcnt_d  = bcnt_q - 3'd1;
      end
      RESP: begin
        if (io_resp_yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight CRC and pending response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      bcnt_q  <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      count_q <= '0;
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
      cycle_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      bcnt_q  <= bcnt_d;
      crc_q   <= crc_d;
      count_q <= count_d;
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
      cycle_q <= cycle_d;
`endif
    end
  end

  assign io_cmd_ready_o = rdy_q && (state_q == IDLE);
  assign busy_o         = (state_q == COMPUTE);
  assign io_resp_v_o    = (state_q == RESP);
  assign io_resp_wr_o   = wr_q;
  assign io_resp_addr_o = addr_q;
  assign io_resp_data_o = rdata_q;

endmodule

// File: tb/tb_bp_sacc_crc32.sv
// Randomized self-checking bench for bp_sacc_crc32 with a table-driven CRC-32 reference.
module tb_bp_sacc_crc32;
  localparam int PA = 40;
`ifdef BP_SACC_CRC32_CYCLE_CNT_EN
  localparam bit CYC = 1'b1;
`else
  localparam bit CYC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_v, cmd_ready, cmd_wr;
  logic [PA-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [63:0]   cmd_data;
  logic          resp_v, resp_yumi, resp_wr, busy;
  logic [PA-1:0] resp_addr;
  logic [63:0]   resp_data;

  bp_sacc_crc32 dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .io_cmd_v_i(cmd_v), .io_cmd_ready_o(cmd_ready), .io_cmd_wr_i(cmd_wr),
    .io_cmd_addr_i(cmd_addr), .io_cmd_size_i(cmd_size), .io_cmd_data_i(cmd_data),
    .io_resp_v_o(resp_v), .io_resp_yumi_i(resp_yumi), .io_resp_wr_o(resp_wr),
    .io_resp_addr_o(resp_addr), .io_resp_data_o(resp_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] crc_tab [256];
  logic [31:0] m_crc;
  logic [31:0] m_count;
  logic [63:0] m_cycle;

  task automatic build_tab();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = 32'(i);
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      crc_tab[i] = v;
    end
  endtask

  task automatic model_reset();
    m_crc = 32'hFFFF_FFFF; m_count = 0; m_cycle = 0;
  endtask

  // Applies one command to the model; returns expected read data and busy cycles.
  task automatic model(input logic wr, input logic [PA-1:0] a, input logic [1:0] sz,
                       input logic [63:0] d, output logic [63:0] exp, output int nbusy);
    int nb;
    logic [5:0] off;
    off = a[5:0];
    exp = 0; nbusy = 0;
    if (wr) begin
      if (off == 6'h00 && d[0]) model_reset();
      else if (off == 6'h08) begin
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) begin
          m_crc = crc_tab[(m_crc ^ 32'(d[8*i +: 8])) & 32'hFF] ^ (m_crc >> 8);
          m_count = m_count + 1;
        end
        m_cycle = m_cycle + 64'(nb);
        nbusy = nb;
      end
    end else begin
      if (off == 6'h10)             exp = {32'b0, ~m_crc};
      else if (off == 6'h18)        exp = {32'b0, m_count};
      else if (off == 6'h20 && CYC) exp = m_cycle;
    end
  endtask

  task automatic do_cmd(input logic wr, input logic [PA-1:0] a, input logic [1:0] sz,
                        input logic [63:0] d, input int ydly, output logic [63:0] rdata);
    logic [63:0] exp;
    int nbusy, nb, t;
    model(wr, a, sz, d, exp, nbusy);
    rdata = '0;
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin chk("cmd_ready_timeout", 0, 1); return; end
    cmd_v = 1; cmd_wr = wr; cmd_addr = a; cmd_size = sz; cmd_data = d;
    @(posedge clk); #1;
    cmd_v = 0;
    nb = 0; t = 0;
    while (!resp_v && t < 100) begin @(negedge clk); if (busy) nb++; t++; end
    if (!resp_v) begin chk("resp_timeout", 0, 1); return; end
    chk("busy_cycles", 64'(nb), 64'(nbusy));
    chk("resp_wr", 64'(resp_wr), 64'(wr));
    chk("resp_addr", 64'(resp_addr), 64'(a));
    chk("resp_data", resp_data, exp);
    chk("ready_in_resp", 64'(cmd_ready), 0);
    rdata = resp_data;
    repeat (ydly) @(negedge clk);
    @(negedge clk); resp_yumi = 1;
    @(posedge clk); #1;
    resp_yumi = 0;
    chk("resp_v_after_yumi", 64'(resp_v), 0);
    chk("ready_after_yumi", 64'(cmd_ready), 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic [PA-1:0] a, la;
    logic [63:0] lrd;
    logic lwr;
    int t;
    build_tab();
    model_reset();
    reset_n = 0; cmd_v = 0; cmd_wr = 0; cmd_addr = '0; cmd_size = 0; cmd_data = '0; resp_yumi = 0;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 0);
    chk("rst_resp_v", 64'(resp_v), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_addr", 64'(resp_addr), 0);
    chk("rst_resp_wr", 64'(resp_wr), 0);
    reset_n = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(cmd_ready), 1);
    chk("post_rst_busy", 64'(busy), 0);
    do_cmd(0, 40'h10, 3, 0, 0, rd);
    chk("post_rst_result", rd, 64'h0);

    // Known check value "123456789"
    do_cmd(1, 40'h00, 3, 64'h1, 0, rd);
    do_cmd(1, 40'h08, 3, 64'h3837363534333231, 0, rd);
    do_cmd(1, 40'h08, 0, 64'h39, 1, rd);
    do_cmd(0, 40'h10, 3, 0, 0, rd);
    chk("check_value", rd, 64'h00000000CBF43926);
    do_cmd(0, 40'h18, 3, 0, 2, rd);
    chk("check_count", rd, 64'd9);

    // Backpressure: response held 20 cycles
    model(1, 40'h08, 2, 64'hDEADBEEF, rd, t);
    @(negedge clk);
    cmd_v = 1; cmd_wr = 1; cmd_addr = 40'h08; cmd_size = 2; cmd_data = 64'hDEADBEEF;
    @(posedge clk); #1; cmd_v = 0;
    t = 0;
    while (!resp_v && t < 100) begin @(negedge clk); t++; end
    chk("bp_resp_seen", 64'(resp_v), 1);
    la = resp_addr; lrd = resp_data; lwr = resp_wr;
    chk("bp_addr", 64'(la), 64'h08);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_resp_v", 64'(resp_v), 1);
      chk("bp_ready", 64'(cmd_ready), 0);
      chk("bp_fields", {resp_data[62:0], resp_wr} ^ 64'(resp_addr),
          {lrd[62:0], lwr} ^ 64'(la));
    end
    resp_yumi = 1;
    @(posedge clk); #1; resp_yumi = 0;
    chk("bp_ready_after", 64'(cmd_ready), 1);
    chk("bp_resp_v_after", 64'(resp_v), 0);

    // Unmapped / illegal accesses leave CRC state intact
    do_cmd(1, 40'h28, 3, 64'hFFFF, 0, rd);
    do_cmd(0, 40'h28, 3, 0, 0, rd);
    do_cmd(0, 40'h00, 3, 0, 0, rd);
    do_cmd(1, 40'h10, 3, 64'h1234, 0, rd);
    do_cmd(0, 40'h10, 3, 0, 0, rd);
    do_cmd(0, 40'h18, 3, 0, 0, rd);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      a = PA'({$urandom(), $urandom()});
      case ($urandom_range(0, 6))
        0: a[5:0] = 6'h00;
        1: a[5:0] = 6'h08;
        2: a[5:0] = 6'h10;
        3: a[5:0] = 6'h18;
        4: a[5:0] = 6'h20;
        5: a[5:0] = 6'h08;
        default: ;
      endcase
      do_cmd(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
             {$urandom(), $urandom()}, $urandom_range(0, 3), rd);
    end

    // Reset in the 3rd compute cycle of an 8-byte write
    @(negedge clk);
    cmd_v = 1; cmd_wr = 1; cmd_addr = 40'h08; cmd_size = 3; cmd_data = 64'h0102030405060708;
    @(posedge clk); #1; cmd_v = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("mid_busy_before_rst", 64'(busy), 1);
    reset_n = 0; #1;
    model_reset();
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_resp_v", 64'(resp_v), 0);
    chk("mid_rst_ready", 64'(cmd_ready), 0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", 64'(resp_v), 0);
    end
    do_cmd(0, 40'h10, 3, 0, 0, rd);
    chk("mid_rst_result", rd, 0);
    do_cmd(0, 40'h18, 3, 0, 0, rd);
    chk("mid_rst_count", rd, 0);

    // Busy-cycle counter
    do_cmd(1, 40'h00, 3, 64'h1, 0, rd);
    do_cmd(1, 40'h08, 3, {$urandom(), $urandom()}, 0, rd);
    do_cmd(1, 40'h08, 3, {$urandom(), $urandom()}, 0, rd);
    do_cmd(0, 40'h20, 3, 0, 0, rd);
    chk("cycle_cnt", rd, CYC ? 64'd16 : 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
